// File: rtl/window_conv_pkg.sv
// Shared widths, types and output saturation for the window convolution block.
package window_conv_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = PIX_W + COEF_W + 1;

    // Clamp a normalised accumulator into the unsigned pixel range.
    function automatic logic [PIX_W-1:0] sat_u8(input logic signed [31:0] v);
        logic [PIX_W-1:0] r;
        if (v < 0)
            r = '0;
        else if (v > 32'sd255)
            r = '1;
        else
            r = v[PIX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/window_conv_row_mac.sv
// One window row: registered pixel x coefficient products, then registered row sum.
module window_row_mac
    import window_conv_pkg::*;
#(
    parameter int W_W   = 5,
    parameter int SUM_W = 22
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [W_W-1:0][PIX_W-1:0]     pix,
    input  logic [W_W-1:0][COEF_W-1:0]    coef,
    output logic signed [SUM_W-1:0]       row_sum
);

    logic signed [PROD_W-1:0] prod [W_W];
    logic signed [SUM_W-1:0]  sum;

    // Pixels are unsigned: zero-extend before the signed multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < W_W; c++)
                prod[c] <= '0;
            row_sum <= '0;
        end else begin
            for (int c = 0; c < W_W; c++)
                prod[c] <= PROD_W'($signed({1'b0, pix[c]}))
                         * PROD_W'($signed(coef[c]));
            row_sum <= sum;
        end
    end

    always_comb begin
        sum = '0;
        for (int c = 0; c < W_W; c++)
            sum = sum + SUM_W'(prod[c]);
    end

endmodule

// File: rtl/window_conv.sv
// Sliding W_H x W_W window with programmable signed 2-D convolution,
// arithmetic normalisation and unsigned 8-bit saturation.
module window_conv
    import window_conv_pkg::*;
#(
    parameter int W_H     = 5,
    parameter int W_W     = 5,
    parameter int ROW_LEN = 2048,
    parameter int SHIFT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sof,
    input  logic                          col_valid,
    input  logic [W_H*PIX_W-1:0]          col_in,
    input  logic                          coef_we,
    input  logic [$clog2(W_H*W_W)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]             coef_data,
    output logic [PIX_W-1:0]              dout,
    output logic                          dout_valid
);

    localparam int N_COEF = W_H * W_W;
    localparam int AW     = $clog2(N_COEF);
    localparam int ACC_W  = PROD_W + $clog2(N_COEF);
    localparam int CW     = $clog2(ROW_LEN);
    localparam int RW     = $clog2(W_H);
    localparam int C_ROW  = (W_H - 1) / 2;
    localparam int C_COL  = (W_W - 1) / 2;

    localparam logic [CW-1:0]     COL_LAST = CW'(ROW_LEN - 1);
    localparam logic [CW-1:0]     COL_MIN  = CW'(W_W - 1);
    localparam logic [RW-1:0]     ROW_MAX  = RW'(W_H - 1);
    localparam logic [COEF_W-1:0] UNITY    = COEF_W'(2 ** SHIFT);

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          win_ok;

    logic [W_H-1:0][W_W-1:0][PIX_W-1:0]  win;
    logic [W_H-1:0][W_W-1:0][COEF_W-1:0] coef;

    logic v1, v2, v3, v4;

    logic signed [ACC_W-1:0] row_sum [W_H];
    logic signed [ACC_W-1:0] total;
    logic signed [ACC_W-1:0] acc;
    logic signed [31:0]      scaled;

    // A start-of-frame pixel is column 0, so it never completes a window.
    assign win_ok = col_valid && !sof
                 && col_cnt >= COL_MIN
                 && row_cnt >= ROW_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (col_valid) begin
            if (sof) begin
                col_cnt <= CW'(1);
                row_cnt <= '0;
            end else if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                if (row_cnt != ROW_MAX)
                    row_cnt <= row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
        end else if (col_valid) begin
            for (int r = 0; r < W_H; r++) begin
                win[r][0] <= col_in[r*PIX_W +: PIX_W];
                for (int c = 1; c < W_W; c++)
                    win[r][c] <= sof ? '0 : win[r][c-1];
            end
        end
    end

    // Out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < W_H; r++)
                for (int c = 0; c < W_W; c++)
                    coef[r][c] <= (r == C_ROW && c == C_COL) ? UNITY : '0;
        end else if (coef_we) begin
            for (int r = 0; r < W_H; r++)
                for (int c = 0; c < W_W; c++)
                    if (coef_addr == AW'(r * W_W + c))
                        coef[r][c] <= coef_data;
        end
    end

    for (genvar r = 0; r < W_H; r++) begin : g_row
        window_row_mac #(
            .W_W   (W_W),
            .SUM_W (ACC_W)
        ) u_row (
            .clk     (clk),
            .rst     (rst),
            .pix     (win[r]),
            .coef    (coef[r]),
            .row_sum (row_sum[r])
        );
    end

    always_comb begin
        total = '0;
        for (int r = 0; r < W_H; r++)
            total = total + row_sum[r];
    end

    assign scaled = 32'(acc >>> SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            v4         <= 1'b0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            v1         <= win_ok;
            v2         <= v1;
            v3         <= v2;
            v4         <= v3;
            acc        <= total;
            dout_valid <= v4;
            if (v4)
                dout <= sat_u8(scaled);
        end
    end

endmodule

// File: tb/tb_window_conv.sv
// Directed checks of window_conv: identity, box, saturation, bubbles,
// mid-row sof/reset and coefficient write timing.
module tb_window_conv;

    logic        clk;
    logic        rst;
    logic        sof;
    logic        col_valid;
    logic [23:0] col_in;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_data;
    logic [7:0]  dout;
    logic        dout_valid;

    int checks;
    int failures;
    int cyc;
    int acc_cyc [24];
    int out_val [$];
    int out_cyc [$];

    window_conv #(
        .W_H     (3),
        .W_W     (3),
        .ROW_LEN (8),
        .SHIFT   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .col_valid  (col_valid),
        .col_in     (col_in),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            out_val.push_back(int'(dout));
            out_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int base, input int n);
        return (n < 0) ? 8'd0 : 8'(base + n);
    endfunction

    function automatic int oval(input int i);
        return (out_val.size() > i) ? out_val[i] : -1;
    endfunction

    function automatic int olat(input int i, input int n);
        return (out_cyc.size() > i) ? out_cyc[i] - acc_cyc[n] : -1;
    endfunction

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr;
        out_val.delete();
        out_cyc.delete();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic wcoef(input int a, input logic [7:0] d);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = d;
        idle(1);
        coef_we   = 1'b0;
    endtask

    // mode 0: ramp base+n with earlier rows n-8, n-16; mode 1: constant base
    task automatic run_seg(input int n0, input int n1, input int base,
                           input int mode, input int gap, input int wr_n);
        for (int n = n0; n <= n1; n++) begin
            sof       = (n == 0);
            col_valid = 1'b1;
            if (mode == 0)
                col_in = {pv(base, n - 16), pv(base, n - 8), pv(base, n)};
            else
                col_in = {3{8'(base)}};
            coef_we   = (n == wr_n);
            coef_addr = 4'd4;
            coef_data = 8'd0;
            acc_cyc[n] = cyc + 1;
            idle(1);
            sof       = 1'b0;
            col_valid = 1'b0;
            coef_we   = 1'b0;
            idle(gap);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        sof       = 1'b0;
        col_valid = 1'b0;
        col_in    = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        @(posedge clk);
        #1;
        do_reset;

        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);

        // identity, continuous ramp
        clr;
        run_seg(0, 23, 0, 0, 0, -1);
        idle(8);
        check("id_cnt", out_val.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("id_val%0d", i), oval(i), 9 + i);
        check("id_lat", olat(0, 18), 4);

        // box filter: 160*18>>4
        do_reset;
        for (int a = 0; a < 9; a++)
            wcoef(a, 8'd2);
        clr;
        run_seg(0, 23, 160, 1, 0, -1);
        idle(8);
        check("box_cnt", out_val.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("box_val%0d", i), oval(i), 180);

        // saturation high and low
        do_reset;
        wcoef(4, 8'd127);
        clr;
        run_seg(0, 23, 200, 1, 0, -1);
        idle(8);
        check("sat_hi_cnt", out_val.size(), 6);
        check("sat_hi_val", oval(0), 255);
        wcoef(4, 8'hf0);
        clr;
        run_seg(0, 23, 50, 1, 0, -1);
        idle(8);
        check("sat_lo_cnt", out_val.size(), 6);
        check("sat_lo_val", oval(0), 0);

        // bubbles: one idle cycle after every accept
        do_reset;
        clr;
        run_seg(0, 23, 0, 0, 1, -1);
        idle(8);
        check("bub_cnt", out_val.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bub_val%0d", i), oval(i), 9 + i);
            check($sformatf("bub_lat%0d", i), olat(i, 18 + i), 4);
        end

        // sof at row 2 col 5: three in-flight results drain, new frame restarts
        do_reset;
        clr;
        run_seg(0, 20, 0, 0, 0, -1);
        run_seg(0, 23, 100, 0, 0, -1);
        idle(8);
        check("sof_cnt", out_val.size(), 9);
        for (int i = 0; i < 3; i++)
            check($sformatf("sof_old%0d", i), oval(i), 9 + i);
        for (int i = 0; i < 6; i++)
            check($sformatf("sof_new%0d", i), oval(3 + i), 109 + i);
        check("sof_lat", olat(3, 18), 4);

        // reset at the same point drops in-flight work and restores identity
        do_reset;
        wcoef(4, 8'd32);
        clr;
        run_seg(0, 20, 0, 0, 0, -1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mrst_valid", int'(dout_valid), 0);
        check("mrst_dout", int'(dout), 0);
        idle(8);
        check("mrst_drop", out_val.size(), 0);
        clr;
        run_seg(0, 23, 0, 0, 0, -1);
        idle(8);
        check("mrst_cnt", out_val.size(), 6);
        check("mrst_ident", oval(0), 9);

        // addr 9 ignored; coef 4 cleared on the accept edge of pixel 20
        do_reset;
        wcoef(9, 8'h7f);
        clr;
        run_seg(0, 23, 0, 0, 0, 20);
        idle(8);
        check("cw_cnt", out_val.size(), 6);
        check("cw_val0", oval(0), 9);
        check("cw_val1", oval(1), 10);
        for (int i = 2; i < 6; i++)
            check($sformatf("cw_val%0d", i), oval(i), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
